// File: rtl/onemax_fitness_eval_if.sv
// Handshake bundle for the OneMax fitness evaluator.
// The master side drives requests and the slave side returns results.
interface onemax_fitness_eval_if #(
   parameter int N_BITS = 1024,
   parameter int FIT_W  = 12
);
   logic              clk_enable;
   logic              start;
   logic [N_BITS-1:0] candidate;
   logic              busy;
   logic              done;
   logic [FIT_W-1:0]  fitness;
   logic              is_optimum;

   modport master (
      output clk_enable, start, candidate,
      input  busy, done, fitness, is_optimum
   );

   modport slave (
      input  clk_enable, start, candidate,
      output busy, done, fitness, is_optimum
   );
endinterface

// File: rtl/onemax_fitness_eval.sv
// OneMax fitness evaluator: counts the ones in a snapshotted candidate,
// one CHUNK_BITS slice per enabled cycle, then pulses done for one cycle.
module onemax_fitness_eval #(
   parameter int N_BITS     = 1024,
   parameter int CHUNK_BITS = 32,
   parameter int FIT_W      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   onemax_fitness_eval_if.slave  bus
);
   localparam int NUM_CHUNKS = N_BITS / CHUNK_BITS;
   localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [N_BITS-1:0] snap_q, snap_d;
   logic [FIT_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FIT_W-1:0]  fitness_q, fitness_d;
   logic              opt_q, opt_d;

   logic [CHUNK_BITS-1:0] chunk;
   logic [FIT_W-1:0]      pop;
   logic [FIT_W-1:0]      sum;
   logic                  last;

   always_comb begin
      chunk = snap_q[int'(idx_q)*CHUNK_BITS +: CHUNK_BITS];
      pop   = '0;
      for (int i = 0; i < CHUNK_BITS; i++) begin
         pop = pop + FIT_W'(chunk[i]);
      end
      sum  = acc_q + pop;
      last = (idx_q == IDX_W'(NUM_CHUNKS - 1));
   end

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      fitness_d = fitness_q;
      opt_d     = opt_q;
      unique case (state_q)
         IDLE: begin
            // start is taken here whether or not clk_enable is high
            if (bus.start) begin
               snap_d  = bus.candidate;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.clk_enable) begin
               acc_d = sum;
               idx_d = idx_q + IDX_W'(1);
               if (last) begin
                  state_d   = DONE;
                  fitness_d = sum;
                  opt_d     = (sum == FIT_W'(N_BITS));
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         fitness_q <= '0;
         opt_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         fitness_q <= fitness_d;
         opt_q     <= opt_d;
      end
   end

   assign bus.busy       = (state_q == ACCUM);
   assign bus.done       = (state_q == DONE);
   assign bus.fitness    = fitness_q;
   assign bus.is_optimum = opt_q;
endmodule

// File: tb/tb_onemax_fitness_eval.sv
// Directed and randomized checks of the OneMax evaluator against a
// popcount reference computed from the candidate with $countones.
module tb_onemax_fitness_eval;
   localparam int N  = 1024;
   localparam int CB = 32;
   localparam int FW = 12;
   localparam int NC = N / CB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   onemax_fitness_eval_if #(.N_BITS(N), .FIT_W(FW)) bus ();

   onemax_fitness_eval #(
      .N_BITS(N), .CHUNK_BITS(CB), .FIT_W(FW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] v;
      for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // mode: 1 = enable every cycle, k>1 = strobe every k-th cycle,
   // 0 = random enable; scr = disturb start/candidate during ACCUM
   task automatic run_eval(input string tag, input logic [N-1:0] cand,
                           input int mode, input bit scr);
      int exp_fit;
      int strobes;
      int cyc;
      bit en;
      exp_fit = $countones(cand);
      bus.candidate  = cand;
      bus.start      = 1'b1;
      bus.clk_enable = (mode == 1);
      tick();
      bus.start = 1'b0;
      chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
      strobes = 0;
      cyc = 0;
      while (strobes < NC && cyc < 4000) begin
         cyc++;
         if (mode == 0) en = 1'($urandom_range(0, 1));
         else en = ((cyc % mode) == 0);
         bus.clk_enable = en;
         if (scr) begin
            bus.candidate = ~cand;
            bus.start = 1'($urandom_range(0, 1));
         end
         tick();
         if (en) strobes++;
         if (strobes < NC)
            chk({tag, "_accum_busy_done"},
                32'({bus.busy, bus.done}), 32'b10);
      end
      chk({tag, "_strobe_budget"}, 32'(strobes), 32'(NC));
      bus.start = 1'b0;
      bus.clk_enable = 1'($urandom_range(0, 1));
      chk({tag, "_done"}, 32'({bus.busy, bus.done}), 32'b01);
      chk({tag, "_fitness"}, 32'(bus.fitness), 32'(exp_fit));
      chk({tag, "_opt"}, 32'(bus.is_optimum), 32'(exp_fit == N));
      tick();
      chk({tag, "_done_width"}, 32'({bus.busy, bus.done}), 32'b00);
      chk({tag, "_fit_hold"}, 32'(bus.fitness), 32'(exp_fit));
      bus.clk_enable = 1'b1;
      tick();
      chk({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'b00);
   endtask

   initial begin
      logic [N-1:0] v;
      bus.start = 1'b0;
      bus.clk_enable = 1'b0;
      bus.candidate = '0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'b00);
      chk("rst_fitness", 32'(bus.fitness), 32'd0);
      chk("rst_opt", 32'(bus.is_optimum), 32'd0);
      bus.start = 1'b1;
      bus.candidate = '1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      chk("start_with_rst_dropped", 32'(bus.busy), 32'd0);
      tick();
      chk("start_with_rst_idle", 32'(bus.busy), 32'd0);

      run_eval("ones", '1, 1, 1'b0);
      run_eval("zeros", '0, 1, 1'b0);
      for (int i = 0; i < N; i++) v[i] = (i % 2 == 1);
      run_eval("aaaa", v, 1, 1'b0);
      v = '0; v[N-1] = 1'b1;
      run_eval("top_bit", v, 1, 1'b0);
      v = '0; v[0] = 1'b1;
      run_eval("bot_bit", v, 1, 1'b0);
      run_eval("strobe4", rand_vec(), 4, 1'b0);
      run_eval("scramble", rand_vec(), 1, 1'b1);
      run_eval("scramble_gated", rand_vec(), 3, 1'b1);

      // abort mid-accumulation after 10 chunks
      bus.candidate = '1;
      bus.start = 1'b1;
      bus.clk_enable = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("abort_pre_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy_done", 32'({bus.busy, bus.done}), 32'b00);
      chk("abort_fitness", 32'(bus.fitness), 32'd0);
      chk("abort_opt", 32'(bus.is_optimum), 32'd0);
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("abort_no_done", 32'({bus.busy, bus.done}), 32'b00);
      end
      run_eval("after_abort", '1, 1, 1'b0);

      for (int k = 0; k < 4; k++) run_eval("rand", rand_vec(), 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/onemax_fitness_eval.md
ONEMAX_FITNESS_EVAL -- requirements
Module: onemax_fitness_eval

Interface
REQ-001 SHALL have parameter N_BITS, default 1024: candidate vector width.
REQ-002 SHALL have parameter CHUNK_BITS, default 32: bits counted per enabled cycle; N_BITS SHALL be a multiple of CHUNK_BITS.
REQ-003 SHALL have parameter FIT_W, default 12: fitness width; SHALL be >= clog2(N_BITS+1).
REQ-004 Derived constant NUM_CHUNKS = N_BITS/CHUNK_BITS (default 32).
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 clk_enable  input  1  advance strobe; shares the one-cycle-per-tick convention of the hill_climbing enable.
REQ-008 start  input  1  one-cycle request to evaluate candidate.
REQ-009 candidate  input  N_BITS  solution to score; sampled only on an accepted start.
REQ-010 busy  output  1  high while accumulating.
REQ-011 done  output  1  one-clk-cycle completion pulse.
REQ-012 fitness  output  FIT_W  count of ones in the last evaluated candidate.
REQ-013 is_optimum  output  1  high when fitness == N_BITS.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: start=1 SHALL be accepted regardless of clk_enable; the same edge snapshots candidate into an internal register, clears accumulator and chunk index, and enters ACCUM.
REQ-016 start SHALL be ignored in ACCUM and DONE; the snapshot SHALL not change until the next accepted start.
REQ-017 ACCUM: on each edge with clk_enable=1, the accumulator SHALL add the popcount of snapshot chunk[idx] (bits idx*CHUNK_BITS +: CHUNK_BITS, idx from 0) and increment idx.
REQ-018 ACCUM: on edges with clk_enable=0, the accumulator, idx, and state SHALL hold.
REQ-019 ACCUM -> DONE SHALL occur on the enabled edge that adds chunk NUM_CHUNKS-1.
REQ-020 On entering DONE, fitness SHALL be loaded with the final sum and is_optimum with (sum == N_BITS).
REQ-021 DONE SHALL last exactly one clk cycle with done=1, independent of clk_enable, and then return to IDLE.
REQ-022 busy SHALL be 1 only in ACCUM.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 fitness and is_optimum SHALL hold their values until the next DONE.
REQ-025 Accumulator width SHALL be FIT_W; the sum SHALL never wrap, because the maximum is N_BITS.
REQ-026 Latency with clk_enable tied high: start in cycle 0, busy in cycles 1..NUM_CHUNKS, done in cycle NUM_CHUNKS+1 (default cycle 33).
REQ-027 Latency with clk_enable gated: done SHALL assert the cycle after the NUM_CHUNKS-th enabled edge following acceptance.
REQ-028 Changes on candidate after acceptance SHALL NOT affect the result.

Reset
REQ-029 rst=1 at an edge SHALL force state IDLE and clear busy, done, fitness, is_optimum, accumulator, idx, and snapshot to 0, with priority over start and clk_enable.
REQ-030 rst asserted mid-ACCUM SHALL abort the evaluation with no done pulse; fitness SHALL read 0 afterwards.
REQ-031 A start coincident with rst SHALL be dropped.

Verification
REQ-032 All-ones candidate, clk_enable=1, start in cycle 0 -> busy in cycles 1..32, done=1 only in cycle 33, fitness=1024, is_optimum=1.
REQ-033 All-zeros candidate, then 0xAAAA...A candidate -> fitness=0 with is_optimum=0, then fitness=512 with is_optimum=0.
REQ-034 Only bit 1023 set, then only bit 0 set -> fitness=1 in both cases (exercises the first and last chunk).
REQ-035 clk_enable high every 4th cycle (one-cycle strobes), start between strobes -> start accepted; done exactly one cycle after the 32nd strobe; done width one cycle.
REQ-036 Second start and candidate inversion during ACCUM -> both ignored; result matches the original candidate; no extra done.
REQ-037 rst pulse at ACCUM chunk 10 -> busy=0, fitness=0, no done; a new start afterwards completes normally.
